relay_memory_ctrl: RTL and testbench
====================================

Name: relay_memory_ctrl

Overview:
Parametrised, clocked successor to the relay computer's 32 KB main memory. It serves handshaked read/write accesses from the control bus with a configurable relay-style access delay. It ignores high address bits above the implemented depth. It adds a streaming preload channel that fills memory from address 0 and reports completion. It sits between the control/address/data buses and the sequencer, and drives the data bus only during an acknowledged read.

Parameters:
ADDR_W, 15, implemented address bits; DEPTH = 2**ADDR_W words
BUS_ADDR_W, 16, address bus width; bits above ADDR_W are ignored
DATA_W, 8, word width
ACCESS_CYCLES, 2, clocks from strobe sample to ack; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
mem_read  in  1  read strobe, level, held until ack then dropped
mem_write  in  1  write strobe, level, same protocol
addr  in  BUS_ADDR_W  address bus; only addr[ADDR_W-1:0] is used
wdata  in  DATA_W  write data, sampled with the strobe
rdata  out  DATA_W  read data
rdata_oe  out  1  data bus drive enable for rdata
ack  out  1  access complete
access_err  out  1  one-cycle pulse: both strobes high in IDLE
busy  out  1  high in any state except IDLE
load_start  in  1  begin preload (sampled only in IDLE)
load_valid  in  1  preload word valid
load_data  in  DATA_W  preload word
load_last  in  1  qualifies the final preload word
load_ready  out  1  preload word accepted when load_valid & load_ready
load_complete  out  1  sticky: preload finished

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset values: state IDLE; rdata=0, rdata_oe=0, ack=0, access_err=0, busy=0, load_ready=0, load_complete=0; counters=0. Memory contents are not cleared.
- States: IDLE, LOAD, ACCESS, HOLD.
- IDLE, one action per edge, first match wins:
  - load_start=1: go to LOAD; ptr=0; load_complete=0.
  - mem_read & mem_write: pulse access_err for 1 cycle; no access; stay IDLE until both strobes drop.
  - Exactly one strobe high: latch addr[ADDR_W-1:0], op, and wdata; cnt=ACCESS_CYCLES-1; go to ACCESS.
- ACCESS:
  - At each edge, if the latched strobe has dropped: abort to IDLE, no write, no ack.
  - Else if cnt=0: write mem[a]=wdata, or load rdata=mem[a]; ack=1; go to HOLD.
  - Else cnt=cnt-1.
  - Ack rises ACCESS_CYCLES edges after the strobe-sampling edge.
- HOLD:
  - ack=1; rdata_oe=1 for reads only, 0 for writes.
  - When the strobe is sampled low: ack=0 and rdata_oe=0 on that edge; go to IDLE. rdata keeps its last value.
  - Exactly one access per strobe assertion; a strobe held high never retriggers.
- LOAD:
  - load_ready=1; mem strobes are ignored.
  - Each accepted word writes mem[ptr]; ptr=ptr+1.
  - Finish on load_last accepted, or on acceptance at ptr=DEPTH-1. On finish: load_complete=1, load_ready=0, go to IDLE.
  - No wrap; words beyond DEPTH are never accepted.
- Address aliasing: addr and addr+2**ADDR_W select the same word.
- load_start outside IDLE is ignored; it is not queued.
- Reset mid-operation: return to the reset state immediately. Words already written remain. An in-flight write that had not reached cnt=0 is not performed.
- Write/read ordering: a read issued after a write's ack returns the new data.

Test Plan:
- Preload 4 words 0x11,0x22,0x33,0x44 with load_last on the 4th -> load_ready drops and load_complete=1 the cycle after acceptance; reads of 0..3 return the preloaded data.
- Read addr 0x0002, ACCESS_CYCLES=2, strobe sampled at edge k -> ack and rdata_oe high after edge k+2, rdata=0x33; after strobe drop, ack=0 and rdata_oe=0 on the next edge.
- Write 0xA5 to addr 0x8005, then read addr 0x0005 -> returns 0xA5 (aliasing); rdata_oe stays 0 throughout the write.
- mem_read and mem_write asserted together in IDLE -> single access_err pulse; no ack; memory unchanged.
- Write strobe dropped after 1 cycle in ACCESS -> no ack; a subsequent read returns the old value.
- Reset asserted mid-LOAD after 2 words, then a new preload of 1 word with load_last -> load_complete=0 during reset; word 1 keeps its first-pass value; word 0 holds the new value.

Source files
------------

// File: rtl/relay_memory_ctrl.sv
// Clocked relay-computer main memory: handshaked read/write with a programmable
// access delay, address aliasing above ADDR_W, and a streaming preload channel.
module relay_memory_ctrl #(
  parameter int ADDR_W        = 15,
  parameter int BUS_ADDR_W    = 16,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [BUS_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rdata_oe,
  output logic                  ack,
  output logic                  access_err,
  output logic                  busy,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_W-1:0]     load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_complete
);
  // Bus handshake: a strobe is a level held until ack, then dropped; dropping it
  // early aborts the access. Preload words transfer when load_valid & load_ready.
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, ACCESS, HOLD} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   a_q;
  logic [ADDR_W-1:0]   ptr;
  logic                op_write;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          cnt;
  logic                err_hold;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                strobe;
  logic                load_fire;
  logic                acc_fire;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                unused_addr;

  assign unused_addr = ^addr[BUS_ADDR_W-1:ADDR_W];

  always_comb begin
    strobe    = op_write ? mem_write : mem_read;
    load_fire = (state == LOAD) && load_valid && load_ready;
    acc_fire  = (state == ACCESS) && op_write && mem_write && (cnt == 4'd0);
    mem_we    = load_fire || acc_fire;
    mem_waddr = load_fire ? ptr : a_q;
    mem_wdata = load_fire ? load_data : wdata_q;
  end

  // Storage has no reset: contents survive reset by design.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      a_q           <= '0;
      ptr           <= '0;
      op_write      <= 1'b0;
      wdata_q       <= '0;
      cnt           <= '0;
      err_hold      <= 1'b0;
      rdata         <= '0;
      rdata_oe      <= 1'b0;
      ack           <= 1'b0;
      access_err    <= 1'b0;
      busy          <= 1'b0;
      load_ready    <= 1'b0;
      load_complete <= 1'b0;
    end else begin
      access_err <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state         <= LOAD;
            ptr           <= '0;
            load_complete <= 1'b0;
            load_ready    <= 1'b1;
            busy          <= 1'b1;
          end else if (err_hold) begin
            // After a conflict, wait for both strobes to drop before rearming.
            if (!mem_read && !mem_write) err_hold <= 1'b0;
          end else if (mem_read && mem_write) begin
            access_err <= 1'b1;
            err_hold   <= 1'b1;
          end else if (mem_read || mem_write) begin
            a_q      <= addr[ADDR_W-1:0];
            op_write <= mem_write;
            wdata_q  <= wdata;
            cnt      <= 4'(ACCESS_CYCLES - 1);
            state    <= ACCESS;
            busy     <= 1'b1;
          end
        end
        ACCESS: begin
          if (!strobe) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == 4'd0) begin
            ack      <= 1'b1;
            rdata_oe <= !op_write;
            if (!op_write) rdata <= mem[a_q];
            state    <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (!strobe) begin
            ack      <= 1'b0;
            rdata_oe <= 1'b0;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end
        LOAD: begin
          if (load_fire) begin
            ptr <= ptr + 1'b1;
            if (load_last || (&ptr)) begin
              load_complete <= 1'b1;
              load_ready    <= 1'b0;
              busy          <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_relay_memory_ctrl.sv
// Directed bench for relay_memory_ctrl: preload, timed reads/writes, aliasing,
// strobe conflict, aborted write and reset during preload.
module tb_relay_memory_ctrl;
  localparam int ADDR_W        = 15;
  localparam int BUS_ADDR_W    = 16;
  localparam int DATA_W        = 8;
  localparam int ACCESS_CYCLES = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  mem_read = 1'b0;
  logic                  mem_write = 1'b0;
  logic [BUS_ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0]     wdata = '0;
  logic [DATA_W-1:0]     rdata;
  logic                  rdata_oe;
  logic                  ack;
  logic                  access_err;
  logic                  busy;
  logic                  load_start = 1'b0;
  logic                  load_valid = 1'b0;
  logic [DATA_W-1:0]     load_data = '0;
  logic                  load_last = 1'b0;
  logic                  load_ready;
  logic                  load_complete;

  int assert_count = 0;
  int fail_count   = 0;

  relay_memory_ctrl #(
    .ADDR_W(ADDR_W), .BUS_ADDR_W(BUS_ADDR_W),
    .DATA_W(DATA_W), .ACCESS_CYCLES(ACCESS_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rdata_oe(rdata_oe), .ack(ack), .access_err(access_err), .busy(busy),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_complete(load_complete)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [BUS_ADDR_W-1:0] a, input logic [DATA_W-1:0] exp,
                         input string tag);
    int n = 0;
    addr = a;
    mem_read = 1'b1;
    do begin
      step();
      n++;
    end while (!ack && n < 20);
    check({tag, "_ack"}, 32'(ack), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(ACCESS_CYCLES + 1));
    check({tag, "_rdata"}, 32'(rdata), 32'(exp));
    check({tag, "_oe"}, 32'(rdata_oe), 32'd1);
    mem_read = 1'b0;
    step();
    check({tag, "_ack_drop"}, 32'(ack), 32'd0);
    check({tag, "_oe_drop"}, 32'(rdata_oe), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic do_write(input logic [BUS_ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input string tag);
    int n = 0;
    logic oe_seen = 1'b0;
    addr = a;
    wdata = d;
    mem_write = 1'b1;
    do begin
      step();
      n++;
      oe_seen = oe_seen | rdata_oe;
    end while (!ack && n < 20);
    check({tag, "_ack"}, 32'(ack), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(ACCESS_CYCLES + 1));
    mem_write = 1'b0;
    step();
    oe_seen = oe_seen | rdata_oe;
    check({tag, "_ack_drop"}, 32'(ack), 32'd0);
    check({tag, "_oe_never"}, 32'(oe_seen), 32'd0);
  endtask

  task automatic start_load(input string tag);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check({tag, "_ready"}, 32'(load_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_cmpl_clr"}, 32'(load_complete), 32'd0);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    #1;
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_oe", 32'(rdata_oe), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(access_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_cmpl", 32'(load_complete), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // Preload four words, last flagged on the fourth
    start_load("ld1");
    push_word(8'h11, 1'b0);
    check("ld1_ready_mid", 32'(load_ready), 32'd1);
    push_word(8'h22, 1'b0);
    push_word(8'h33, 1'b0);
    push_word(8'h44, 1'b1);
    check("ld1_ready_end", 32'(load_ready), 32'd0);
    check("ld1_cmpl", 32'(load_complete), 32'd1);
    check("ld1_busy_end", 32'(busy), 32'd0);
    do_read(16'h0000, 8'h11, "rd0");
    do_read(16'h0001, 8'h22, "rd1");
    do_read(16'h0002, 8'h33, "rd2");
    do_read(16'h0003, 8'h44, "rd3");

    // Write through an aliased address, read back via the low alias
    do_write(16'h8005, 8'hA5, "wr_alias");
    do_read(16'h0005, 8'hA5, "rd_alias");

    // Both strobes together: one error pulse, no access
    addr = 16'h0000;
    wdata = 8'hFF;
    mem_read = 1'b1;
    mem_write = 1'b1;
    step();
    check("conf_err", 32'(access_err), 32'd1);
    check("conf_busy", 32'(busy), 32'd0);
    step();
    check("conf_err_pulse", 32'(access_err), 32'd0);
    check("conf_no_ack", 32'(ack), 32'd0);
    check("conf_held_idle", 32'(busy), 32'd0);
    mem_read = 1'b0;
    mem_write = 1'b0;
    step();
    do_read(16'h0000, 8'h11, "rd_conf");

    // Write aborted after one cycle in ACCESS
    addr = 16'h0001;
    wdata = 8'h77;
    mem_write = 1'b1;
    step();
    check("abort_busy", 32'(busy), 32'd1);
    mem_write = 1'b0;
    step();
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_no_ack", 32'(ack), 32'd0);
    step();
    check("abort_no_ack2", 32'(ack), 32'd0);
    do_read(16'h0001, 8'h22, "rd_abort");

    // Reset in the middle of a preload, then a one-word preload
    start_load("ld2");
    push_word(8'h55, 1'b0);
    push_word(8'h66, 1'b0);
    reset = 1'b1;
    #1;
    check("rstld_cmpl", 32'(load_complete), 32'd0);
    check("rstld_ready", 32'(load_ready), 32'd0);
    check("rstld_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    step();
    start_load("ld3");
    push_word(8'h99, 1'b1);
    check("ld3_cmpl", 32'(load_complete), 32'd1);
    check("ld3_ready_end", 32'(load_ready), 32'd0);
    do_read(16'h0000, 8'h99, "rd_new0");
    do_read(16'h0001, 8'h66, "rd_keep1");
    do_read(16'h0002, 8'h33, "rd_keep2");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
